enc_4to2_scan: RTL and testbench

Sequential 4-to-2 encoder that serves as the counterpart to the 2-to-4 decoder. It accepts a 4-bit request vector over a valid/ready handshake and emits the 2-bit binary index of every set bit, one index per handshake, in priority order. A vector with a single set bit is a plain one-hot-to-binary encode. Multi-bit vectors are serialised, so a downstream `dec_2to4` reconstructs each original line in turn.

---
 rtl/enc_4to2_scan.sv | 117 +++++++++++
 tb/tb_enc_4to2_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/enc_4to2_scan.sv
// enc_4to2_scan: sequential 4-to-2 encoder that serialises set bits.
// Counterpart to dec_2to4; emits one binary index per output handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in[k] requests index k
//   out_valid/out_ready output handshake; out is the current index
//   out_last            current index is the final one of the vector
//   count               popcount of the last accepted vector
//   zero                one-cycle pulse on an all-zero accept
//   LSB_FIRST           1: ascending index order, 0: descending
module enc_4to2_scan #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out,
    output logic       out_last,
    output logic [2:0] count,
    output logic       zero
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] pend;
    logic [1:0] idx;
    logic       accept;
    logic       beat;

    function automatic logic [1:0] lowest(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [1:0] highest(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] popcount(input logic [3:0] p);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 4; i++) begin
            s = s + {2'b00, p[i]};
        end
        return s;
    endfunction

    generate
        if (LSB_FIRST) begin : g_lsb
            assign idx = lowest(pend);
        end else begin : g_msb
            assign idx = highest(pend);
        end
    endgenerate

    // Outputs depend only on state and pend, so they cannot glitch
    // with in and they stay put while out_ready is low.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign out       = idx;
    // Exactly one bit set: nonzero and clearing the lowest bit leaves 0.
    assign out_last  = (pend != 4'd0) &&
                       ((pend & (pend - 4'd1)) == 4'd0);

    assign accept = in_valid && in_ready;
    assign beat   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 4'd0;
            count <= 3'd0;
            zero  <= 1'b0;
        end else begin
            zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count <= popcount(in);
                        if (in == 4'd0) begin
                            zero <= 1'b1;
                        end else begin
                            pend  <= in;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (beat) begin
                        pend <= pend & ~(4'b0001 << idx);
                        if (out_last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_4to2_scan.sv
// tb_enc_4to2_scan: directed bench for enc_4to2_scan.
// Drives and samples 1 time unit after each rising edge.
module tb_enc_4to2_scan;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0] a_in;
    logic [1:0] a_out;
    logic       a_out_last, a_zero;
    logic [2:0] a_count;

    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [3:0] d_in;
    logic [1:0] d_out;
    logic       d_out_last, d_zero;
    logic [2:0] d_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc_4to2_scan #(.LSB_FIRST(1'b1)) u_asc (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out(a_out), .out_last(a_out_last),
        .count(a_count), .zero(a_zero)
    );

    enc_4to2_scan #(.LSB_FIRST(1'b0)) u_desc (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in(d_in),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out(d_out), .out_last(d_out_last),
        .count(d_count), .zero(d_zero)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dec_2to4(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Check one ascending-instance beat as seen in the current cycle.
    task automatic beat_a(input string tag, input int o, input int l);
        chk({tag, ".valid"}, int'(a_out_valid), 1);
        chk({tag, ".out"},   int'(a_out), o);
        chk({tag, ".last"},  int'(a_out_last), l);
        chk({tag, ".ready"}, int'(a_in_ready), 0);
    endtask

    task automatic beat_d(input string tag, input int o, input int l);
        chk({tag, ".valid"}, int'(d_out_valid), 1);
        chk({tag, ".out"},   int'(d_out), o);
        chk({tag, ".last"},  int'(d_out_last), l);
    endtask

    logic [3:0] onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in = 0; a_out_ready = 1;
        d_in_valid = 0; d_in = 0; d_out_ready = 1;
        step(); step();
        chk("rst.in_ready",  int'(a_in_ready), 1);
        chk("rst.out_valid", int'(a_out_valid), 0);
        chk("rst.out",       int'(a_out), 0);
        chk("rst.out_last",  int'(a_out_last), 0);
        chk("rst.count",     int'(a_count), 0);
        chk("rst.zero",      int'(a_zero), 0);
        rst = 1'b0;
        step();

        // One-hot sweep, ascending.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in = onehot[i];
            chk("oh.idle_ready", int'(a_in_ready), 1);
            step();
            a_in_valid = 0; a_in = 4'd0;
            beat_a("oh", i, 1);
            chk("oh.count", int'(a_count), 1);
            chk("oh.dec", int'(dec_2to4(a_out)), int'(onehot[i]));
            step();
            chk("oh.done_valid", int'(a_out_valid), 0);
            chk("oh.done_ready", int'(a_in_ready), 1);
        end

        // Multi-bit 1011 -> 0,1,3.
        a_in_valid = 1; a_in = 4'b1011;
        step();
        a_in_valid = 0;
        beat_a("mb0", 0, 0);
        chk("mb.count", int'(a_count), 3);
        step(); beat_a("mb1", 1, 0);
        step(); beat_a("mb3", 3, 1);
        step();
        chk("mb.in_ready", int'(a_in_ready), 1);
        chk("mb.valid_off", int'(a_out_valid), 0);

        // Descending 1111 -> 3,2,1,0.
        d_in_valid = 1; d_in = 4'b1111;
        step();
        d_in_valid = 0;
        chk("ds.count", int'(d_count), 4);
        chk("ds.in_ready", int'(d_in_ready), 0);
        beat_d("ds3", 3, 0);
        step(); beat_d("ds2", 2, 0);
        step(); beat_d("ds1", 1, 0);
        step(); beat_d("ds0", 0, 1);
        step();
        chk("ds.valid_off", int'(d_out_valid), 0);
        chk("ds.in_ready1", int'(d_in_ready), 1);

        // Backpressure 0110, extra input ignored while scanning.
        a_out_ready = 0;
        a_in_valid = 1; a_in = 4'b0110;
        step();
        a_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            beat_a("bp.hold", 1, 0);
            step();
        end
        chk("bp.count", int'(a_count), 2);
        a_out_ready = 1;
        beat_a("bp1", 1, 0);
        step();
        a_in_valid = 0; a_in = 4'd0;
        beat_a("bp2", 2, 1);
        chk("bp.count2", int'(a_count), 2);
        step();
        chk("bp.done_valid", int'(a_out_valid), 0);
        chk("bp.done_ready", int'(a_in_ready), 1);

        // Zero vector then back-to-back 0100.
        a_in_valid = 1; a_in = 4'b0000;
        step();
        chk("zv.zero", int'(a_zero), 1);
        chk("zv.count", int'(a_count), 0);
        chk("zv.valid", int'(a_out_valid), 0);
        chk("zv.in_ready", int'(a_in_ready), 1);
        a_in = 4'b0100;
        step();
        a_in_valid = 0; a_in = 4'd0;
        chk("zv.zero_off", int'(a_zero), 0);
        chk("zv.count1", int'(a_count), 1);
        beat_a("zv2", 2, 1);
        step();
        chk("zv.done", int'(a_out_valid), 0);

        // Reset mid-scan.
        a_in_valid = 1; a_in = 4'b1111;
        step();
        a_in_valid = 0;
        beat_a("rs0", 0, 0);
        chk("rs.count", int'(a_count), 4);
        step();
        beat_a("rs1", 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs.valid", int'(a_out_valid), 0);
        chk("rs.count0", int'(a_count), 0);
        chk("rs.in_ready", int'(a_in_ready), 1);
        chk("rs.last", int'(a_out_last), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs.no_beat", int'(a_out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
